// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write signals of the imem loader.
// master: stream source / observer side; slave: the loader itself.
interface imem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  i_Start;
  logic                  i_Byte_Valid;
  logic [7:0]            i_Byte;
  logic                  o_Byte_Ready;
  logic                  o_Imem_Write_Enable;
  logic [ADDR_WIDTH-1:0] o_Imem_Address;
  logic [DATA_WIDTH-1:0] o_Imem_Write_Data;
  logic                  o_Core_Reset;
  logic                  o_Busy;
  logic                  o_Done;
  logic                  o_Error;

  modport master (
    output i_Start, i_Byte_Valid, i_Byte,
    input  o_Byte_Ready, o_Imem_Write_Enable, o_Imem_Address, o_Imem_Write_Data,
    input  o_Core_Reset, o_Busy, o_Done, o_Error
  );

  modport slave (
    input  i_Start, i_Byte_Valid, i_Byte,
    output o_Byte_Ready, o_Imem_Write_Enable, o_Imem_Address, o_Imem_Write_Data,
    output o_Core_Reset, o_Busy, o_Done, o_Error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a count byte N followed by 4*N
// little-endian data bytes, writes each assembled word to imem and holds the
// core in reset until the image is complete.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over all data bytes before the load is declared done.
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 64
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("imem_loader: DATA_WIDTH must be 32");
  end
  if (MEM_DEPTH > 255 || MEM_DEPTH > (1 << ADDR_WIDTH) || MEM_DEPTH < 1) begin : g_bad_depth
    $error("imem_loader: MEM_DEPTH out of range");
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle, StCount, StBytes, StWrite, StDone, StError, StCheck
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StCount, StBytes, StWrite, StDone, StError
  } state_e;
`endif

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic [1:0]            lane_q, lane_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            count_q, count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic xfer;
  logic last_word;

  assign xfer      = bus.i_Byte_Valid && ready_q;
  // Word index has reached N-1, so the current WRITE is the final one.
  assign last_word = (32'(addr_q) + 32'd1) == 32'(count_q);

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      lane_q  <= 2'd0;
      word_q  <= '0;
      addr_q  <= '0;
      count_q <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      count_q <= count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    addr_d  = addr_q;
    count_d = count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (bus.i_Start) begin
          state_d = StCount;
          lane_d  = 2'd0;
          word_d  = '0;
          addr_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = 8'd0;
`endif
        end
      end
      StCount: begin
        if (xfer) begin
          count_d = bus.i_Byte;
          if (bus.i_Byte == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
`endif
          end else if (32'(bus.i_Byte) > 32'(MEM_DEPTH)) begin
            state_d = StError;
          end else begin
            state_d = StBytes;
          end
        end
      end
      StBytes: begin
        if (xfer) begin
          word_d[{lane_q, 3'b000} +: 8] = bus.i_Byte;
          lane_d = lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.i_Byte;
`endif
          if (lane_q == 2'd3) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        // Address is held on the last word so it never passes N-1.
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StBytes;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (xfer) begin
          state_d = (bus.i_Byte == csum_q) ? StDone : StError;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StCount) || (state_d == StBytes);
`ifdef IMEM_LOADER_CHECKSUM_EN
    ready_d = ready_d || (state_d == StCheck);
`endif
  end

  // Outputs decode directly from registered state.
  assign bus.o_Byte_Ready        = ready_q;
  assign bus.o_Imem_Write_Enable = (state_q == StWrite);
  assign bus.o_Imem_Address      = addr_q;
  assign bus.o_Imem_Write_Data   = word_q;
  assign bus.o_Core_Reset        = (state_q != StDone);
  assign bus.o_Done              = (state_q == StDone);
  assign bus.o_Error             = (state_q == StError);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.o_Busy = (state_q == StCount) || (state_q == StBytes) ||
                      (state_q == StWrite) || (state_q == StCheck);
`else
  assign bus.o_Busy = (state_q == StCount) || (state_q == StBytes) || (state_q == StWrite);
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes
// (address, data, cycle) and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int DataWidth = 32;
  localparam int AddrWidth = 8;
  localparam int MemDepth  = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CkExtra = 1;
`else
  localparam int CkExtra = 0;
`endif

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  logic prev_we;
  exp_t sb[$];
  logic [31:0] img [64];

  imem_loader_if #(.DATA_WIDTH(DataWidth), .ADDR_WIDTH(AddrWidth)) bus ();

  imem_loader #(
    .DATA_WIDTH(DataWidth),
    .ADDR_WIDTH(AddrWidth),
    .MEM_DEPTH (MemDepth)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.o_Imem_Write_Enable === 1'b1) begin
      chk("strobe_one_cycle", 32'(prev_we), 32'd0);
      if (sb.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                 bus.o_Imem_Address, bus.o_Imem_Write_Data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("write_addr", 32'(bus.o_Imem_Address), 32'(e.addr));
        chk("write_data", bus.o_Imem_Write_Data, e.data);
        chk("write_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_we = bus.o_Imem_Write_Enable;
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(output int s);
    bus.i_Start = 1'b1;
    s = cyc;
    align();
    bus.i_Start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    bus.i_Byte_Valid = 1'b1;
    bus.i_Byte       = b;
    @(negedge clk);
    while (bus.o_Byte_Ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n = n + 1;
    end
    if (bus.o_Byte_Ready !== 1'b1) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL send_timeout: ready=%b, expected 1 within 50 cycles", bus.o_Byte_Ready);
    end
    align();
    bus.i_Byte_Valid = 1'b0;
  endtask

  // Streams img[0..n-1]; optionally stalls 3 cycles after data byte stall_after.
  task automatic load_image(input int n, input int stall_after, output int done_cyc);
    int   s;
    int   extra;
    exp_t e;
    logic [7:0] b;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'd0;
`endif
    extra = 0;
    start_pulse(s);
    send(8'(n));
    for (int i = 0; i < n; i++) begin
      extra  = (stall_after > 0 && stall_after < 4 * (i + 1)) ? 3 : 0;
      e.addr = 8'(i);
      e.data = img[i];
      e.cyc  = s + 6 + 5 * i + extra;
      sb.push_back(e);
      for (int bb = 0; bb < 4; bb++) begin
        b = img[i][8*bb +: 8];
`ifdef IMEM_LOADER_CHECKSUM_EN
        x = x ^ b;
`endif
        send(b);
        if (4 * i + bb + 1 == stall_after) begin
          repeat (3) @(posedge clk);
          #1;
        end
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(x);
`endif
    done_cyc = s + 6 + 5 * (n - 1) + 1 + extra + CkExtra;
  endtask

  task automatic wait_end(input logic want_done, input int exp_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.o_Done !== 1'b1 && bus.o_Error !== 1'b1 && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("end_done", 32'(bus.o_Done), 32'(want_done));
    chk("end_error", 32'(bus.o_Error), 32'(!want_done));
    chk("end_core_reset", 32'(bus.o_Core_Reset), 32'(!want_done));
    chk("end_cycle", 32'(cyc), 32'(exp_cyc));
    align();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   s;
    int   dc;
    logic ok_cr, ok_rdy, ok_done;
    exp_t e;
    checks = 0;
    errors = 0;
    cyc    = 0;
    prev_we = 1'b0;
    reset  = 1'b1;
    bus.i_Start      = 1'b0;
    bus.i_Byte_Valid = 1'b0;
    bus.i_Byte       = 8'd0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_core_reset", 32'(bus.o_Core_Reset), 32'd1);
    chk("rst_ready", 32'(bus.o_Byte_Ready), 32'd0);
    chk("rst_busy", 32'(bus.o_Busy), 32'd0);
    chk("rst_addr", 32'(bus.o_Imem_Address), 32'd0);
    chk("rst_data", bus.o_Imem_Write_Data, 32'd0);
    reset = 1'b0;

    // Idle for 20 cycles: core held, nothing accepted, no writes.
    ok_cr = 1'b1; ok_rdy = 1'b1; ok_done = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_Core_Reset !== 1'b1) ok_cr = 1'b0;
      if (bus.o_Byte_Ready !== 1'b0) ok_rdy = 1'b0;
      if (bus.o_Done !== 1'b0) ok_done = 1'b0;
    end
    chk("idle_core_reset", 32'(ok_cr), 32'd1);
    chk("idle_ready_low", 32'(ok_rdy), 32'd1);
    chk("idle_done_low", 32'(ok_done), 32'd1);
    align();

    // Two-word image back-to-back.
    img[0] = 32'h1234_5678;
    img[1] = 32'hDEAD_BEEF;
    load_image(2, -1, dc);
    wait_end(1'b1, dc);

    // Same image, valid dropped 3 cycles after the second data byte.
    load_image(2, 2, dc);
    wait_end(1'b1, dc);

    // Reset mid-load after 6 data bytes.
    start_pulse(s);
    send(8'd2);
    e.addr = 8'd0; e.data = img[0]; e.cyc = s + 6;
    sb.push_back(e);
    for (int bb = 0; bb < 4; bb++) send(img[0][8*bb +: 8]);
    send(img[1][7:0]);
    send(img[1][15:8]);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_core_reset", 32'(bus.o_Core_Reset), 32'd1);
    chk("abort_ready", 32'(bus.o_Byte_Ready), 32'd0);
    chk("abort_busy", 32'(bus.o_Busy), 32'd0);
    chk("abort_addr", 32'(bus.o_Imem_Address), 32'd0);
    chk("abort_data", bus.o_Imem_Write_Data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    align();
    load_image(2, -1, dc);
    wait_end(1'b1, dc);

    // Full-depth image: addresses 0..63, address parks at 63.
    for (int i = 0; i < MemDepth; i++) begin
      img[i] = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
    end
    load_image(MemDepth, -1, dc);
    wait_end(1'b1, dc);
    chk("full_last_addr", 32'(bus.o_Imem_Address), 32'd63);

    // Restart from DONE reasserts core reset on the very next edge.
    start_pulse(s);
    chk("restart_core_reset", 32'(bus.o_Core_Reset), 32'd1);
    chk("restart_busy", 32'(bus.o_Busy), 32'd1);
    chk("restart_done", 32'(bus.o_Done), 32'd0);

    // Oversized count aborts with no writes.
    send(8'h41);
    @(negedge clk);
    chk("over_error", 32'(bus.o_Error), 32'd1);
    chk("over_core_reset", 32'(bus.o_Core_Reset), 32'd1);
    chk("over_ready", 32'(bus.o_Byte_Ready), 32'd0);
    chk("over_busy", 32'(bus.o_Busy), 32'd0);
    align();

    // Empty image from ERROR.
    start_pulse(s);
    send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    @(negedge clk);
    chk("empty_done", 32'(bus.o_Done), 32'd1);
    chk("empty_core_reset", 32'(bus.o_Core_Reset), 32'd0);
    chk("empty_error", 32'(bus.o_Error), 32'd0);
    align();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good and bad checksum over 01 02 04 08.
    for (int k = 0; k < 2; k++) begin
      start_pulse(s);
      send(8'd1);
      e.addr = 8'd0; e.data = 32'h0804_0201; e.cyc = s + 6;
      sb.push_back(e);
      send(8'h01); send(8'h02); send(8'h04); send(8'h08);
      send(k == 0 ? 8'h0F : 8'h0E);
      wait_end(k == 0, s + 8);
    end
`endif

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
